// File: rtl/fetch_unit.sv
// picoMIPS instruction fetch stage: owns the PC, drives the synchronous program ROM
// address and buffers returned words with their PC in a 2-entry prefetch FIFO.
module fetch_unit #(
   parameter int Psize = 4,
   parameter int Isize = 17
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   output logic [Psize-1:0] imem_addr,
   input  logic [Isize-1:0] imem_data,
   output logic [Isize-1:0] instr,
   output logic [Psize-1:0] instr_pc,
   output logic             instr_valid,
   input  logic             instr_ready,
   input  logic             branch,
   input  logic [Psize-1:0] branch_target
);

   logic [Psize-1:0] pc;
   logic [Psize-1:0] issued_pc;
   logic             inflight;

   logic [Isize-1:0] fifo_instr [2];
   logic [Psize-1:0] fifo_pc    [2];
   logic             rd_ptr;
   logic             wr_ptr;
   logic [1:0]       count;

   logic             pop;
   logic             push;
   logic             issue;
   logic [2:0]       occupancy;

   assign imem_addr   = branch ? branch_target : pc;
   assign instr_valid = (count != 2'd0);
   assign instr       = fifo_instr[rd_ptr];
   assign instr_pc    = fifo_pc[rd_ptr];

   assign pop  = instr_valid & instr_ready;
   assign push = inflight & ~branch;

   // Entries the FIFO will hold once the outstanding response lands; keeping
   // this below 2 at issue time is what guarantees a push never overflows.
   assign occupancy = {1'b0, count} - {2'b0, pop} + {2'b0, inflight};
   assign issue     = en & (branch | (occupancy < 3'd2));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc        <= '0;
         issued_pc <= '0;
         inflight  <= 1'b0;
      end else begin
         inflight <= issue;
         if (issue) begin
            pc        <= imem_addr + Psize'(1);
            issued_pc <= imem_addr;
         end else if (branch) begin
            pc <= branch_target;
         end
      end
   end

   // A branch flushes everything, including a head consumed in the same cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fifo_instr[0] <= '0;
         fifo_instr[1] <= '0;
         fifo_pc[0]    <= '0;
         fifo_pc[1]    <= '0;
         rd_ptr        <= 1'b0;
         wr_ptr        <= 1'b0;
         count         <= '0;
      end else if (branch) begin
         rd_ptr <= 1'b0;
         wr_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) begin
            fifo_instr[wr_ptr] <= imem_data;
            fifo_pc[wr_ptr]    <= issued_pc;
            wr_ptr             <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed per-cycle vector table, random traffic checked
// against an in-order expected-PC scoreboard, and an asynchronous mid-stream reset.
module tb_fetch_unit;

   localparam int Psize = 4;
   localparam int Isize = 17;

   logic             clk = 1'b0;
   logic             reset;
   logic             en;
   logic [Psize-1:0] imem_addr;
   logic [Isize-1:0] imem_data;
   logic [Isize-1:0] instr;
   logic [Psize-1:0] instr_pc;
   logic             instr_valid;
   logic             instr_ready;
   logic             branch;
   logic [Psize-1:0] branch_target;

   logic [Isize-1:0] rom [16];

   int checks = 0;
   int errors = 0;

   fetch_unit #(.Psize(Psize), .Isize(Isize)) dut (
      .clk           (clk),
      .reset         (reset),
      .en            (en),
      .imem_addr     (imem_addr),
      .imem_data     (imem_data),
      .instr         (instr),
      .instr_pc      (instr_pc),
      .instr_valid   (instr_valid),
      .instr_ready   (instr_ready),
      .branch        (branch),
      .branch_target (branch_target)
   );

   always #5 clk = ~clk;

   // Synchronous program ROM: data for last cycle's address
   always @(posedge clk) imem_data <= rom[imem_addr];

   typedef struct {
      logic       en;
      logic       ready;
      logic       br;
      logic [3:0] tgt;
      logic       exp_valid;
      logic [3:0] exp_pc;
      logic [3:0] exp_addr;
   } vec_t;

   vec_t vecs[$];

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic e, input logic r, input logic b, input logic [3:0] t,
                               input logic v, input logic [3:0] p, input logic [3:0] a);
      vec_t x;
      x.en = e; x.ready = r; x.br = b; x.tgt = t;
      x.exp_valid = v; x.exp_pc = p; x.exp_addr = a;
      return x;
   endfunction

   initial begin
      logic [3:0] exp_next;
      logic       b1, b1en, b2en;
      int         streak;
      logic       hold;
      logic [Isize-1:0] prev_instr;
      logic [Psize-1:0] prev_pc;

      // stream, backpressure, branch while full, wrap, branch with en=0 + pop, drain
      vecs.push_back(mk(1,1,0,0, 0,0, 0));
      vecs.push_back(mk(1,1,0,0, 0,0, 1));
      vecs.push_back(mk(1,1,0,0, 1,0, 2));
      vecs.push_back(mk(1,0,0,0, 1,1, 3));
      vecs.push_back(mk(1,0,0,0, 1,1, 3));
      vecs.push_back(mk(1,0,0,0, 1,1, 3));
      vecs.push_back(mk(1,1,0,0, 1,1, 3));
      vecs.push_back(mk(1,1,0,0, 1,2, 4));
      vecs.push_back(mk(1,1,0,0, 1,3, 5));
      vecs.push_back(mk(1,0,0,0, 1,4, 6));
      vecs.push_back(mk(1,0,1,9, 1,4, 9));
      vecs.push_back(mk(1,1,0,0, 0,0, 10));
      vecs.push_back(mk(1,1,0,0, 1,9, 11));
      vecs.push_back(mk(1,1,0,0, 1,10, 12));
      vecs.push_back(mk(1,1,0,0, 1,11, 13));
      vecs.push_back(mk(1,1,0,0, 1,12, 14));
      vecs.push_back(mk(1,1,0,0, 1,13, 15));
      vecs.push_back(mk(1,1,0,0, 1,14, 0));
      vecs.push_back(mk(1,1,0,0, 1,15, 1));
      vecs.push_back(mk(1,1,0,0, 1,0, 2));
      vecs.push_back(mk(1,1,0,0, 1,1, 3));
      vecs.push_back(mk(0,1,1,5, 1,2, 5));
      vecs.push_back(mk(0,1,0,0, 0,0, 5));
      vecs.push_back(mk(1,1,0,0, 0,0, 5));
      vecs.push_back(mk(1,1,0,0, 0,0, 6));
      vecs.push_back(mk(1,1,0,0, 1,5, 7));
      vecs.push_back(mk(0,1,0,0, 1,6, 8));
      vecs.push_back(mk(0,1,0,0, 1,7, 8));
      vecs.push_back(mk(0,1,0,0, 0,0, 8));

      for (int k = 0; k < 16; k++) rom[k] = Isize'(k * 4099 + 5);

      reset = 1'b0; en = 1'b1; instr_ready = 1'b0; branch = 1'b0; branch_target = '0;
      repeat (3) @(negedge clk);
      check("reset_valid", 32'(instr_valid), 0);
      check("reset_addr",  32'(imem_addr), 0);
      check("reset_pc",    32'(instr_pc), 0);
      check("reset_instr", 32'(instr), 0);

      reset = 1'b1;
      foreach (vecs[i]) begin
         en = vecs[i].en; instr_ready = vecs[i].ready;
         branch = vecs[i].br; branch_target = vecs[i].tgt;
         #1;
         check($sformatf("vec%0d_valid", i), 32'(instr_valid), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d_addr", i), 32'(imem_addr), 32'(vecs[i].exp_addr));
         if (vecs[i].exp_valid) begin
            check($sformatf("vec%0d_pc", i), 32'(instr_pc), 32'(vecs[i].exp_pc));
            check($sformatf("vec%0d_instr", i), 32'(instr), 32'(rom[vecs[i].exp_pc]));
         end
         @(negedge clk);
      end

      // Random traffic: every delivered word must be the next PC of the current
      // straight-line run, redirected to the target on each branch.
      for (int k = 0; k < 16; k++) rom[k] = Isize'($urandom);
      exp_next = 4'd8;
      b1 = 1'b0; b1en = 1'b0; b2en = 1'b0; streak = 0; hold = 1'b0;
      prev_instr = '0; prev_pc = '0;
      for (int c = 0; c < 500; c++) begin
         if (b1) check("rand_flush_invalid", 32'(instr_valid), 0);
         if (b2en && !b1) check("rand_target_valid", 32'(instr_valid), 1);
         if (streak >= 3) check("rand_liveness", 32'(instr_valid), 1);
         if (hold) begin
            check("rand_hold_valid", 32'(instr_valid), 1);
            check("rand_hold_pc", 32'(instr_pc), 32'(prev_pc));
            check("rand_hold_instr", 32'(instr), 32'(prev_instr));
         end
         en            = ($urandom_range(0, 9) != 0);
         instr_ready   = ($urandom_range(0, 3) != 0);
         branch        = ($urandom_range(0, 11) == 0);
         branch_target = Psize'($urandom);
         #1;
         if (branch) check("rand_branch_addr", 32'(imem_addr), 32'(branch_target));
         if (instr_valid && instr_ready) begin
            check("rand_pc", 32'(instr_pc), 32'(exp_next));
            check("rand_instr", 32'(instr), 32'(rom[exp_next]));
            exp_next = exp_next + 4'd1;
         end
         if (branch) exp_next = branch_target;
         hold       = instr_valid && !instr_ready && !branch;
         prev_pc    = instr_pc;
         prev_instr = instr;
         b2en = b1en; b1 = branch; b1en = branch && en;
         streak = (en && !branch) ? streak + 1 : 0;
         @(negedge clk);
      end

      // Fill the FIFO with 3,4 then reset asynchronously mid-cycle
      en = 1'b1; instr_ready = 1'b0; branch = 1'b1; branch_target = 4'd3;
      @(negedge clk);
      branch = 1'b0;
      repeat (4) @(negedge clk);
      check("pre_reset_valid", 32'(instr_valid), 1);
      check("pre_reset_pc", 32'(instr_pc), 3);
      #2 reset = 1'b0;
      #1;
      check("midreset_valid", 32'(instr_valid), 0);
      check("midreset_pc", 32'(instr_pc), 0);
      check("midreset_instr", 32'(instr), 0);
      check("midreset_addr", 32'(imem_addr), 0);
      @(negedge clk);
      reset = 1'b1; instr_ready = 1'b1;
      #1 check("restart_c0_valid", 32'(instr_valid), 0);
      @(negedge clk);
      #1 check("restart_c1_valid", 32'(instr_valid), 0);
      @(negedge clk);
      #1;
      check("restart_c2_valid", 32'(instr_valid), 1);
      check("restart_c2_pc", 32'(instr_pc), 0);
      check("restart_c2_instr", 32'(instr), 32'(rom[0]));
      @(negedge clk);
      #1 check("restart_c3_pc", 32'(instr_pc), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
